// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   DM_SEL_*  : encodings of the CPU dm_sel access-size field
//   state_e   : responder state (post-reset clear sweep, then idle service)
package dmem_pkg;

  localparam logic [2:0] DM_SEL_WORD = 3'd0;
  localparam logic [2:0] DM_SEL_HALF = 3'd1;
  localparam logic [2:0] DM_SEL_BYTE = 3'd2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane control for stores and alignment checking.
//   addr_lo_i  [1:0]  low byte-address bits
//   sel_i      [2:0]  access size (word/half/byte, others reserved)
//   wdata_i    [31:0] right-aligned store data
//   byte_en_o  [3:0]  lanes written by a store
//   wdata_o    [31:0] store data replicated onto every candidate lane
//   misalign_o        address not aligned to the access size
//   sel_rsvd_o        dm_sel holds a reserved encoding
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        sel_rsvd_o
);

  always_comb begin
    byte_en_o  = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    sel_rsvd_o = 1'b0;
    case (sel_i)
      DM_SEL_WORD: begin
        byte_en_o  = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      DM_SEL_HALF: begin
        byte_en_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {wdata_i[15:0], wdata_i[15:0]};
        misalign_o = addr_lo_i[0];
      end
      DM_SEL_BYTE: begin
        byte_en_o  = 4'b0001 << addr_lo_i;
        wdata_o    = {4{wdata_i[7:0]}};
      end
      default: begin
        sel_rsvd_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the CPU load/store port.
//   clk, reset           system clock; synchronous active-low reset
//   dm_ena/dm_w/dm_r     access enable, store request, load request
//   dm_sel [2:0]         access size (0 word, 1 half, 2 byte)
//   addr   [31:0]        byte address; wdata [31:0] right-aligned store data
//   dm_data [31:0]       combinational load data, zero-extended, right-aligned
//   busy                 post-reset clear sweep in progress (requests ignored)
//   err, err_addr        sticky fault flag and first faulting address; err_clr clears
//   rd_cnt, wr_cnt       wrapping counts of accepted loads / committed stores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned AW          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dm_ena,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [2:0]  dm_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] dm_data,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            err_q;
  logic [31:0]     err_addr_q;
  logic [31:0]     rd_cnt_q, wr_cnt_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_al;
  logic            misalign;
  logic            sel_rsvd;
  logic            access;
  logic            fault;
  logic            ld_ok;
  logic            st_ok;
  logic [31:0]     rd_word;
  logic [15:0]     rd_half;
  logic [7:0]      rd_byte;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // DEPTH_WORDS is a power of two, so the last index is all ones.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (&clr_idx_q) begin
        state_d = ST_IDLE;
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  // ---------------- Decode ----------------
  dmem_lane_ctrl u_lane_ctrl (
    .addr_lo_i  (addr[1:0]),
    .sel_i      (dm_sel),
    .wdata_i    (wdata),
    .byte_en_o  (byte_en),
    .wdata_o    (wdata_al),
    .misalign_o (misalign),
    .sel_rsvd_o (sel_rsvd)
  );

  always_comb begin
    off      = addr - BASE_ADDR;
    idx      = off[AW+1:2];
    in_range = (addr >= BASE_ADDR) && (off < SPAN_BYTES);
    access   = !busy && dm_ena && (dm_r || dm_w);
    fault    = access && (!in_range || misalign || sel_rsvd);
    ld_ok    = !busy && dm_ena && dm_r && !fault;
    st_ok    = !busy && dm_ena && dm_w && !fault;
  end

  // ---------------- Read mux ----------------
  always_comb begin
    rd_word = mem_q[idx];
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    dm_data = '0;
    if (ld_ok) begin
      case (dm_sel)
        DM_SEL_WORD: dm_data = rd_word;
        DM_SEL_HALF: dm_data = {16'b0, rd_half};
        DM_SEL_BYTE: dm_data = {24'b0, rd_byte};
        default:     dm_data = '0;
      endcase
    end
  end

  // ---------------- Memory array ----------------
  // No reset on the array itself: the clear sweep zeroes it after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (busy) begin
        mem_q[clr_idx_q] <= '0;
      end else if (st_ok) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            mem_q[idx][8*b +: 8] <= wdata_al[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------- Fault capture ----------------
  // A fault coinciding with err_clr re-arms and captures the new address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (fault && (!err_q || err_clr)) begin
      err_q      <= 1'b1;
      err_addr_q <= addr;
    end else if (err_clr) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end
  end

  // ---------------- Access counters ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (ld_ok) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (st_ok) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam int          DEPTH  = 2048;
  localparam int          NBYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        dm_ena, dm_w, dm_r;
  logic [2:0]  dm_sel;
  logic [31:0] addr, wdata;
  logic [31:0] dm_data;
  logic        busy, err;
  logic [31:0] err_addr;
  logic        err_clr;
  logic [31:0] rd_cnt, wr_cnt;

  dmem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .AW          (11)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dm_ena   (dm_ena),
    .dm_w     (dm_w),
    .dm_r     (dm_r),
    .dm_sel   (dm_sel),
    .addr     (addr),
    .wdata    (wdata),
    .dm_data  (dm_data),
    .busy     (busy),
    .err      (err),
    .err_addr (err_addr),
    .err_clr  (err_clr),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte-addressed memory plus status registers.
  logic [7:0]  m_mem [NBYTES];
  logic        m_err;
  logic [31:0] m_err_addr, m_rd, m_wr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int m_size(input logic [2:0] sel);
    if (sel == 3'd0) return 4;
    if (sel == 3'd1) return 2;
    return 1;
  endfunction

  function automatic bit m_fault(input logic [2:0] sel, input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (a < BASE || o >= NBYTES) return 1'b1;
    if (sel > 3'd2) return 1'b1;
    if ((a % m_size(sel)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_err = 1'b0; m_err_addr = '0; m_rd = '0; m_wr = '0;
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
  endtask

  task automatic drive_idle();
    dm_ena = 1'b0; dm_r = 1'b0; dm_w = 1'b0; dm_sel = 3'd0;
    addr = '0; wdata = '0; err_clr = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check load data before the edge,
  // advance the model, check registered state after the edge.
  task automatic access(input bit ena, input bit r, input bit w, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] wd, input bit clr,
                        input string tag, output logic [31:0] got);
    logic [31:0] exp_data;
    bit          flt;
    int          o, n;
    @(negedge clk);
    dm_ena = ena; dm_r = r; dm_w = w; dm_sel = sel; addr = a; wdata = wd; err_clr = clr;
    #1;
    flt = ena && (r || w) && m_fault(sel, a);
    n = m_size(sel);
    o = int'(a - BASE);
    exp_data = '0;
    if (ena && r && !flt)
      for (int i = 0; i < n; i++) exp_data |= 32'(m_mem[o + i]) << (8 * i);
    got = dm_data;
    check({tag, " dm_data"}, dm_data, exp_data);
    if (ena && !flt) begin
      if (r) m_rd = m_rd + 32'd1;
      if (w) begin
        m_wr = m_wr + 32'd1;
        for (int i = 0; i < n; i++) m_mem[o + i] = wd[8*i +: 8];
      end
    end
    if (flt && (!m_err || clr)) begin
      m_err = 1'b1; m_err_addr = a;
    end else if (clr) begin
      m_err = 1'b0; m_err_addr = '0;
    end
    @(posedge clk);
    #1;
    check({tag, " err"}, {31'b0, err}, {31'b0, m_err});
    check({tag, " err_addr"}, err_addr, m_err_addr);
    check({tag, " rd_cnt"}, rd_cnt, m_rd);
    check({tag, " wr_cnt"}, wr_cnt, m_wr);
    drive_idle();
  endtask

  // Count negedges with busy high, starting at the reset-release negedge.
  // With poke set, requests are driven throughout and must be ignored.
  task automatic sweep_count(input bit poke, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      if (poke) begin
        dm_ena = 1'b1; dm_r = 1'b1; dm_w = 1'b1; wdata = 32'hFFFF_FFFF;
        dm_sel = cnt[0] ? 3'd0 : 3'd2;
        addr   = cnt[0] ? (BASE + 32'd2) : (BASE + 32'd8);
        #1;
        check("busy dm_data", dm_data, 32'h0);
      end
      cnt++;
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_reset();
  endtask

  logic [31:0] got;
  int          cnt;
  logic [31:0] ra, rwd;
  logic [2:0]  rsel;
  int          mode;

  initial begin
    reset = 1'b0;
    drive_idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'd1);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset err_addr", err_addr, 32'h0);
    check("reset rd_cnt", rd_cnt, 32'h0);
    check("reset wr_cnt", wr_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    sweep_count(1'b1, cnt);
    check("sweep length", 32'(cnt), 32'(DEPTH));
    check("post-sweep err", {31'b0, err}, 32'd0);
    check("post-sweep rd_cnt", rd_cnt, 32'h0);
    check("post-sweep wr_cnt", wr_cnt, 32'h0);

    for (int i = 0; i < DEPTH; i++)
      access(1, 1, 0, 3'd0, BASE + 32'(4 * i), 32'h0, 0, "zero word", got);

    // Directed cases
    access(1, 0, 1, 3'd0, 32'h1001_0004, 32'hDEAD_BEEF, 0, "st word", got);
    access(1, 1, 0, 3'd2, 32'h1001_0005, 32'h0, 0, "ld byte", got);
    check("ld byte const", got, 32'h0000_00BE);
    access(1, 1, 0, 3'd1, 32'h1001_0006, 32'h0, 0, "ld half", got);
    check("ld half const", got, 32'h0000_DEAD);
    access(1, 0, 1, 3'd2, 32'h1001_0007, 32'h0000_0012, 0, "st byte", got);
    access(1, 1, 0, 3'd0, 32'h1001_0004, 32'h0, 0, "ld merged", got);
    check("ld merged const", got, 32'h12AD_BEEF);
    check("wr_cnt after two stores", wr_cnt, 32'd2);

    access(1, 1, 0, 3'd0, 32'h1001_0002, 32'h0, 0, "misaligned ld", got);
    check("misaligned data const", got, 32'h0);
    check("misaligned err const", {31'b0, err}, 32'd1);
    check("misaligned err_addr const", err_addr, 32'h1001_0002);
    access(1, 0, 1, 3'd0, 32'h0000_0000, 32'h5555_5555, 0, "oob st", got);
    check("first fault held", err_addr, 32'h1001_0002);
    check("oob st no count", wr_cnt, 32'd2);
    access(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, "err_clr", got);
    check("err cleared", {31'b0, err}, 32'd0);

    access(1, 1, 0, 3'd0, 32'h1001_0003, 32'h0, 0, "fault A", got);
    access(1, 1, 0, 3'd1, 32'h1001_0011, 32'h0, 1, "fault+clr", got);
    check("fault+clr captures", err_addr, 32'h1001_0011);
    access(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, "err_clr 2", got);
    access(1, 1, 0, 3'd5, 32'h1001_0020, 32'h0, 0, "rsvd sel", got);
    access(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, "err_clr 3", got);

    access(1, 0, 1, 3'd0, BASE + 32'(NBYTES - 4), 32'hCAFE_F00D, 0, "st top", got);
    access(1, 1, 0, 3'd0, BASE + 32'(NBYTES - 4), 32'h0, 0, "ld top", got);
    access(1, 1, 0, 3'd2, BASE + 32'(NBYTES), 32'h0, 0, "ld past end", got);
    access(1, 1, 0, 3'd2, BASE - 32'd1, 32'h0, 1, "ld below base", got);
    access(0, 0, 0, 3'd0, 32'h0, 32'h0, 1, "err_clr 4", got);

    access(1, 0, 1, 3'd0, 32'h1001_0020, 32'h0102_0304, 0, "st pre", got);
    access(1, 1, 1, 3'd0, 32'h1001_0020, 32'hA0B0_C0D0, 0, "rd+wr", got);
    check("rd+wr old data", got, 32'h0102_0304);
    access(1, 1, 0, 3'd0, 32'h1001_0020, 32'h0, 0, "rd after rd+wr", got);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      mode = $urandom_range(0, 19);
      if (mode == 0)      ra = BASE - 32'($urandom_range(1, 16));
      else if (mode == 1) ra = BASE + 32'(NBYTES) + 32'($urandom_range(0, 15));
      else if (mode == 2) ra = BASE + 32'(NBYTES) - 32'($urandom_range(1, 8));
      else                ra = BASE + 32'($urandom_range(0, 63));
      rsel = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rwd  = $urandom;
      access($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), rsel, ra, rwd,
             $urandom_range(0, 9) == 0, "rand", got);
    end

    // Counter wrap from a forced preload
    @(negedge clk);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    m_rd = 32'hFFFF_FFFF;
    #1;
    check("rd_cnt preload", rd_cnt, 32'hFFFF_FFFF);
    access(1, 1, 0, 3'd0, BASE, 32'h0, 0, "wrap ld", got);
    check("rd_cnt wrapped", rd_cnt, 32'h0);

    // Reset mid-sweep restarts the sweep and clears the counters
    apply_reset();
    for (int c = 0; c < 100; c++) begin
      dm_ena = 1'b1; dm_r = 1'b1; dm_w = 1'b1; dm_sel = 3'd0;
      addr = BASE + 32'd8; wdata = 32'h7777_7777;
      #1;
      check("mid busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    sweep_count(1'b0, cnt);
    check("restarted sweep length", 32'(cnt), 32'(DEPTH));
    check("mid reset rd_cnt", rd_cnt, 32'h0);
    check("mid reset wr_cnt", wr_cnt, 32'h0);
    check("mid reset err", {31'b0, err}, 32'd0);
    access(1, 1, 0, 3'd0, BASE + 32'd8, 32'h0, 0, "mid reset ld", got);
    access(1, 1, 0, 3'd0, BASE + 32'(NBYTES - 4), 32'h0, 0, "mid reset top", got);
    access(1, 1, 0, 3'd0, 32'h1001_0004, 32'h0, 0, "mid reset w1", got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
